// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// UART transmit frame sequencer. Latches one word per valid/ready handshake
// and shifts it onto the serial line as start, data (LSB first), optional
// parity and stop bits, advancing one bit per t_tick pulse.
module uart_tx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 resetN,
    input  logic                 t_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_line,
    output logic                 busy,
    output logic                 done
);

    localparam int             CW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic           LAST_STOP = (STOP_BITS == 2);
    localparam logic           ODD_SEL   = (PARITY_ODD != 0);
    localparam logic           PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_line;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;

    assign w_accept = tx_valid && r_ready;

    // Frame FSM: handshake capture, per-tick bit sequencing and registered outputs.
    // The shift register is consumed LSB first, so the current data bit is always r_shift[0];
    // parity is computed once at capture time from the full latched word.
    always_ff @(posedge clk_in or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_line     <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ ODD_SEL;
                        r_state  <= S_ARMED;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (t_tick) begin
                        r_line  <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (t_tick) begin
                        r_line    <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (t_tick) begin
                        if (r_bit_cnt < LAST_BIT) begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                            r_line    <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end else if (PAR_ON) begin
                            r_line  <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_line     <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (t_tick) begin
                        r_line     <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (t_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign busy     = r_busy;
    assign tx_line  = r_line;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer
// Directed bench for uart_tx_sequencer. Four instances share the input
// stimulus: default framing, even parity, odd parity and two stop bits.
module tb_uart_tx_sequencer;

    logic       clk;
    logic       resetN;
    logic       t_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] line_v;
    logic [3:0] ready_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;

    int n_cmp;
    int n_err;
    int phase;

    uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
        .clk_in(clk), .resetN(resetN), .t_tick(t_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[0]), .tx_line(line_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_pe (
        .clk_in(clk), .resetN(resetN), .t_tick(t_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[1]), .tx_line(line_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_po (
        .clk_in(clk), .resetN(resetN), .t_tick(t_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[2]), .tx_line(line_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_s2 (
        .clk_in(clk), .resetN(resetN), .t_tick(t_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[3]), .tx_line(line_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle; t_tick is high on the edge that ends phase period-1.
    task automatic step(input int period);
        t_tick = (phase == period - 1);
        @(posedge clk);
        #1;
        phase = (phase + 1) % period;
    endtask

    task automatic reset_all();
        tx_valid = 1'b0;
        t_tick   = 1'b0;
        resetN   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b1;
        phase  = 0;
    endtask

    // Present a word for one edge, then withdraw it and scramble the data bus.
    task automatic send(input logic [7:0] data, input int period, input logic keep_valid);
        tx_data  = data;
        tx_valid = 1'b1;
        step(period);
        if (!keep_valid) begin
            tx_valid = 1'b0;
            tx_data  = ~data;
        end
    endtask

    task automatic wait_start(input int idx, input int period, input int bound, output int waited);
        waited = 0;
        while (line_v[idx] !== 1'b0 && waited < bound) begin
            step(period);
            waited++;
        end
        if (line_v[idx] !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout dut%0d: line=%b after %0d cycles, required 0", idx, line_v[idx], waited);
            waited = -1;
        end
    endtask

    // Follows one frame from its start bit: every bit must hold for exactly one tick period,
    // then done/tx_ready must appear together on the cycle after the last stop tick.
    task automatic check_frame(input int idx, input int period, input logic [15:0] exp,
                               input int nbits, input string name, output int waited);
        int bad;
        int dn;
        logic [3:0] got;
        dn = 0;
        wait_start(idx, period, 4 * period + 4, waited);
        if (waited < 0) return;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < period; c++) begin
                if (!(b == 0 && c == 0)) step(period);
                if (line_v[idx] !== exp[b]) bad++;
                if (done_v[idx] !== 1'b0) dn++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL %s_bit%0d: %0d of %0d cycles wrong, line=%b required %b",
                         name, b, bad, period, line_v[idx], exp[b]);
            end
        end
        n_cmp++;
        if (dn != 0) begin
            n_err++;
            $display("FAIL %s_early_done: %0d done cycles inside frame, required 0", name, dn);
        end
        step(period);
        got = {done_v[idx], ready_v[idx], busy_v[idx], line_v[idx]};
        n_cmp++;
        if (got !== 4'b1101) begin
            n_err++;
            $display("FAIL %s_end: done/ready/busy/line=%b required 1101", name, got);
        end
        step(period);
        n_cmp++;
        if (done_v[idx] !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done_width: done=%b one cycle later, required 0", name, done_v[idx]);
        end
    endtask

    task automatic test_reset();
        int bad;
        resetN   = 1'b1;
        tx_valid = 1'b0;
        t_tick   = 1'b0;
        tx_data  = 8'h00;
        @(posedge clk); #1;
        resetN = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1'($urandom);
            t_tick   = 1'($urandom);
            tx_data  = 8'($urandom);
            @(posedge clk); #1;
            if ({line_v, ready_v, busy_v, done_v} !== 16'hFF00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_values: line/ready/busy/done=%h in %0d cycles, required ff00",
                     {line_v, ready_v, busy_v, done_v}, bad);
        end
        tx_valid = 1'b0;
        resetN   = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            t_tick = 1'($urandom);
            @(posedge clk); #1;
            if ({line_v, ready_v, busy_v, done_v} !== 16'hFF00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_hold: %0d of 100 cycles wrong, last=%h required ff00",
                     bad, {line_v, ready_v, busy_v, done_v});
        end
    endtask

    task automatic test_single_frame();
        int w;
        reset_all();
        send(8'h55, 16, 1'b0);
        n_cmp++;
        if ({busy_v[0], ready_v[0], line_v[0]} !== 3'b101) begin
            n_err++;
            $display("FAIL accept_state: busy/ready/line=%b required 101", {busy_v[0], ready_v[0], line_v[0]});
        end
        check_frame(0, 16, 16'h02AA, 10, "frame55", w);
        n_cmp++;
        if (w != 15) begin
            n_err++;
            $display("FAIL frame55_latency: start after %0d cycles, required 15", w);
        end
    endtask

    task automatic test_parity_even();
        int w;
        reset_all();
        send(8'h07, 4, 1'b0);
        check_frame(1, 4, 16'h060E, 11, "par_even", w);
    endtask

    task automatic test_parity_odd();
        int w;
        reset_all();
        send(8'h07, 4, 1'b0);
        check_frame(2, 4, 16'h040E, 11, "par_odd", w);
    endtask

    task automatic test_back_to_back();
        int w1;
        int w2;
        reset_all();
        send(8'hA3, 8, 1'b1);
        tx_data = 8'h3C;
        check_frame(0, 8, 16'h0346, 10, "b2b_a3", w1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        n_cmp++;
        if (busy_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b after ready rose with valid held, required 1", busy_v[0]);
        end
        check_frame(0, 8, 16'h0278, 10, "b2b_3c", w2);
        n_cmp++;
        if (w2 != 7) begin
            n_err++;
            $display("FAIL b2b_gap: second start after %0d cycles, required 7", w2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int bad;
        reset_all();
        send(8'h00, 8, 1'b0);
        wait_start(0, 8, 40, w);
        for (int i = 0; i < 34; i++) step(8);
        n_cmp++;
        if (line_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_bit3: line=%b required 0", line_v[0]);
        end
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({line_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
            n_err++;
            $display("FAIL async_reset: line/ready/busy/done=%b required 1100",
                     {line_v[0], ready_v[0], busy_v[0], done_v[0]});
        end
        step(8);
        step(8);
        resetN = 1'b1;
        bad = 0;
        for (int i = 0; i < 96; i++) begin
            step(8);
            if (done_v[0] !== 1'b0 || line_v[0] !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL dropped_frame: %0d cycles with done or line low, required 0", bad);
        end
        send(8'hFF, 8, 1'b0);
        check_frame(0, 8, 16'h03FE, 10, "after_reset_ff", w);
    endtask

    task automatic test_tick_coincidence();
        int w;
        reset_all();
        phase = 5;
        send(8'h96, 6, 1'b0);
        n_cmp++;
        if ({busy_v[3], line_v[3]} !== 2'b11) begin
            n_err++;
            $display("FAIL coincide_accept: busy/line=%b required 11", {busy_v[3], line_v[3]});
        end
        check_frame(3, 6, 16'h072C, 11, "stop2", w);
        n_cmp++;
        if (w != 6) begin
            n_err++;
            $display("FAIL coincide_latency: start after %0d cycles, required 6", w);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        phase    = 0;
        resetN   = 1'b1;
        t_tick   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_single_frame();
        test_parity_even();
        test_parity_odd();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_coincidence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
